// File: rtl/pe_pkg.sv
// Shared types and helpers for the priority-encoder unit.
// Holds the decoder FSM state enum, line count and the code-to-line mapping,
// which the encoder bench also uses as its reference.
package pe_pkg;

    localparam int unsigned PE_LINES  = 8;
    localparam int unsigned PE_CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Code 0 selects the top line (7) and code 7 selects line 0.
    function automatic logic [PE_LINES-1:0] code_to_line(input logic [PE_CODE_W-1:0] code);
        logic [PE_LINES-1:0] line;
        line = '0;
        line[3'd7 - code] = 1'b1;
        return line;
    endfunction

endpackage

// File: rtl/pe_hold_counter.sv
// Loadable down-counter that times the strobe hold period.
// Ports: clk, rst_n (async active-low clear), load_i/load_val_i (parallel load),
//        dec_i (decrement, saturating at zero), zero_o (count is zero).
module pe_hold_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority over decrement; decrement never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pe_code_decoder.sv
// Sequential 3-to-8 decoder: turns an accepted encoder code back into a
// one-hot line strobe held for HOLD_CYCLES cycles, followed by a one-cycle gap.
// Ports: clk, rst_n (async active-low), en (enable / abort), valid + code
//        (request), ready (accept possible, combinational), y (registered
//        one-hot strobe), busy (strobe or gap active), done (normal-completion pulse).
module pe_code_decoder
    import pe_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 valid,
    input  logic [PE_CODE_W-1:0] code,
    output logic                 ready,
    output logic [PE_LINES-1:0]  y,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t              state_q, state_d;
    logic [PE_LINES-1:0] y_q, y_d;
    logic                done_q, done_d;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;

    pe_hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (HOLD_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state and registered-output logic. An en drop in HOLD wins over
    // the final count, so an abort never produces done.
    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid && en) begin
                    y_d      = code_to_line(code);
                    cnt_load = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!en) begin
                    y_d     = '0;
                    state_d = GAP;
                end else if (cnt_zero) begin
                    y_d     = '0;
                    done_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GAP: begin
                y_d     = '0;
                state_d = IDLE;
            end
            default: begin
                y_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign ready = en && (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign y     = y_q;
    assign done  = done_q;

endmodule

// File: doc/pe_code_decoder.md
# pe_code_decoder

Sequential 3-to-8 decoder that takes the 3-bit code produced by the unit's 8-line priority encoder and drives the matching output line as a timed one-hot strobe. Code mapping matches the encoder: code 3'b000 selects line 7 and code 3'b111 selects line 0, so `y[7-code]`. It sits downstream of the encoder, turning an encoded request back into a held line select. A valid/ready handshake paces requests, and a `done` pulse marks the end of each strobe.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: number of cycles the selected line is held high. Legal range 1..255.
- `CNT_W`, default `$clog2(HOLD_CYCLES+1)`: width of the hold counter. Derived, not overridden.

Ports:
- `clk`  input  1  single clock; all logic is on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  block enable. Low means no accepts, and it aborts an active strobe.
- `valid`  input  1  `code` is valid this cycle.
- `code`  input  3  encoded line number; line 7 is 3'b000.
- `ready`  output  1  block can accept a code this cycle.
- `y`  output  8  registered one-hot line strobe.
- `busy`  output  1  strobe or gap in progress.
- `done`  output  1  one-cycle pulse when a strobe completes normally.

## Operation
- FSM has three states: IDLE, HOLD and GAP.
- IDLE:
  - `ready` = `en` (combinational).
  - On an edge with `valid && ready`: `y` <= one-hot with bit (7-`code`) set, counter <= `HOLD_CYCLES`-1, and the FSM goes to HOLD.
  - `valid` without `ready` is ignored. Nothing is queued.
- HOLD:
  - `y` holds its value and the counter decrements each cycle.
  - When the counter is 0 and `en`=1: `y` <= 0, `done` <= 1, and the FSM goes to GAP.
  - When `en`=0 at any edge in HOLD (abort): `y` <= 0, `done` stays 0, and the FSM goes to GAP.
- GAP:
  - Exactly one cycle with `y`=0. `done` is high only if the previous HOLD completed normally.
  - The FSM then goes to IDLE.
- `busy` = (state != IDLE). `ready` is 0 whenever `busy` is 1.
- `code` is sampled only on the accept edge. Later changes to `code` do not affect `y`.
- `y` is never multi-hot. It is either all-zero or has exactly one bit set.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE, `y`=8'h00, `done`=0, `busy`=0, counter=0. `ready` then follows `en`.
- Reset asserted mid-HOLD or mid-GAP forces the reset values immediately, with no `done` pulse.
- Latency: for an accept at edge k, `y` is valid from edge k+1 through edge k+`HOLD_CYCLES`.
- `y`=0 and `done`=1 from edge k+`HOLD_CYCLES`+1 for exactly one cycle (the GAP cycle).
- `ready` returns at edge k+`HOLD_CYCLES`+2 if `en`=1.
- Maximum throughput is one accept per `HOLD_CYCLES`+2 cycles.
- When `HOLD_CYCLES`=1, `y` is high for exactly one cycle.
- An abort at edge a (`en`=0 sampled in HOLD) gives `y`=0 from edge a+1, GAP for one cycle, then IDLE.
- Simultaneous `en` drop and final hold count: the abort wins, and there is no `done`.

## Structure
- Shared package `pe_pkg` holds:
  - the `state_t` enum (IDLE, HOLD, GAP);
  - the constant `PE_LINES`=8;
  - the function `code_to_line(code)`, which returns a one-hot with bit (7-`code`) set. The encoder bench reuses it as its reference model.
- One sub-module, `pe_hold_counter`: a loadable down-counter of width `CNT_W` with `load`, `dec` and a `zero` flag, asynchronously cleared by `rst_n`.

## Test plan
- Reset: assert `rst_n`=0 mid-HOLD with `y`=8'h80 -> `y`=8'h00, `busy`=0 and `done`=0 immediately; after release with `en`=1, `ready`=1.
- Full code sweep: `HOLD_CYCLES`=4, `en`=1, codes 0..7 each sent as soon as `ready`=1 -> `y` is 8'h80, 8'h40, …, 8'h01, each for 4 cycles then 1 zero cycle with `done`=1; accepts are spaced 6 cycles apart.
- Back-pressure: hold `valid`=1 with `code`=3'b010 continuously -> only one accept per 6 cycles; `y`=8'h20 each time; `ready` is never 1 while `busy`=1.
- Abort: accept `code`=3'b101 (`y`=8'h04), then drop `en` on the 2nd hold cycle -> `y`=8'h00 the next cycle, `done` never pulses, and `ready` stays 0 until `en` returns.
- Simultaneous: drop `en` exactly on the edge where the counter reaches 0 -> no `done`, and the GAP cycle is still present.
- Minimum hold: `HOLD_CYCLES`=1, `code`=3'b111 -> `y`=8'h01 for 1 cycle, `done` on the next cycle, and `ready` 3 cycles after the accept.
